// File: rtl/game_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_pkg
// Description : Shared types, constants and BCD helpers for the round timer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_timer_pkg;

    // Largest value a single BCD digit may hold
    localparam int BCD_MAX = 9;
    // Largest round length the two-digit display can show
    localparam int SEC_MAX = 99;

    // Round control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Binary seconds to packed {tens, ones} BCD; used on constants only
    function automatic logic [7:0] to_bcd(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

    // One-second BCD decrement; 00 is held rather than wrapped
    function automatic logic [7:0] bcd_dec(input logic [7:0] value);
        if (value[3:0] != 4'd0) begin
            return {value[7:4], value[3:0] - 4'd1};
        end else if (value[7:4] != 4'd0) begin
            return {value[7:4] - 4'd1, 4'(BCD_MAX)};
        end else begin
            return value;
        end
    endfunction

endpackage : game_timer_pkg
`default_nettype wire

// File: rtl/game_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_if
// Description : Control inputs and display/status outputs of the round timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_timer_if;

    logic       tick_in;
    logic       start;
    logic       pause;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       running;
    logic       paused;
    logic       time_up;
    logic       game_over;

    // Game controller side: drives controls, observes the timer
    modport master (
        output tick_in, start, pause,
        input  secs_tens, secs_ones, running, paused, time_up, game_over
    );

    // Timer side
    modport slave (
        input  tick_in, start, pause,
        output secs_tens, secs_ones, running, paused, time_up, game_over
    );

endinterface : game_timer_if
`default_nettype wire

// File: rtl/game_timer_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Registered rising-edge detector for a same-domain level signal.
//               One-cycle pulse, one cycle after the input is first sampled high.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Remember last sample and flag a 0->1 transition on the next edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            in_q  <= in;
            pulse <= in & ~in_q;
        end
    end

endmodule : rise_detect
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Whack-a-Mole round countdown. Counts START_SECONDS down to 00
//               in BCD on rising edges of the 1 Hz divider output, with pause,
//               a one-cycle time_up pulse and a game_over level.
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer
    import game_timer_pkg::*;
#(
    parameter int START_SECONDS = 60
) (
    input  logic        clock,
    input  logic        reset,
    game_timer_if.slave bus
);

    localparam logic [7:0] START_BCD = to_bcd(START_SECONDS);

    // Two digits cannot show zero-length or three-digit rounds
    generate
        if (START_SECONDS < 1 || START_SECONDS > SEC_MAX) begin : g_bad_start_seconds
            $fatal(1, "game_timer: START_SECONDS must be in 1..99");
        end
    endgenerate

    logic       sec_tick;
    state_t     state;
    state_t     state_next;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tens_next;
    logic [3:0] ones_next;
    logic       time_up_next;
    logic       running_q;
    logic       paused_q;
    logic       time_up_q;
    logic       game_over_q;

    rise_detect u_tick_detect (
        .clock (clock),
        .reset (reset),
        .in    (bus.tick_in),
        .pulse (sec_tick)
    );

    // State, digit and flag registers; flags are decoded from the next state
    // so every output comes straight from a flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tens        <= START_BCD[7:4];
            ones        <= START_BCD[3:0];
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            time_up_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state       <= state_next;
            tens        <= tens_next;
            ones        <= ones_next;
            running_q   <= (state_next == RUN);
            paused_q    <= (state_next == PAUSED);
            time_up_q   <= time_up_next;
            game_over_q <= (state_next == DONE);
        end
    end

    // Next state: pause takes priority over a tick; start only acts when idle or done
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.pause) begin
                    state_next = PAUSED;
                end else if (sec_tick && tens == 4'd0 && ones == 4'd1) begin
                    state_next = DONE;
                end
            end
            PAUSED: begin
                if (!bus.pause) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next digits and expiry pulse; a start swallows any coincident tick
    always_comb begin
        tens_next    = tens;
        ones_next    = ones;
        time_up_next = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    tens_next = START_BCD[7:4];
                    ones_next = START_BCD[3:0];
                end
            end
            RUN: begin
                if (!bus.pause && sec_tick) begin
                    {tens_next, ones_next} = bcd_dec({tens, ones});
                    time_up_next           = (tens == 4'd0 && ones == 4'd1);
                end
            end
            default: begin
                tens_next = tens;
                ones_next = ones;
            end
        endcase
    end

    assign bus.secs_tens = tens;
    assign bus.secs_ones = ones;
    assign bus.running   = running_q;
    assign bus.paused    = paused_q;
    assign bus.time_up   = time_up_q;
    assign bus.game_over = game_over_q;

endmodule : game_timer
`default_nettype wire
